// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable depth (any value >= 2), optional
// first-word-fall-through read mode, almost-full/almost-empty flags and sticky
// overflow/underflow error flags.
//
// Ports:
//   clk_i          sole clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   wr_en_i        write request
//   wr_data_i      write data
//   rd_en_i        read (pop) request
//   rd_data_o      read data (registered)
//   wr_full_o      level == FIFO_DEPTH
//   rd_empty_o     level == 0
//   almost_full_o  level >= AFULL_THRESH
//   almost_empty_o level <= AEMPTY_THRESH
//   level_o        stored word count
//   overflow_o     sticky: write attempted while full
//   underflow_o    sticky: read attempted while empty
//   err_clr_i      synchronous clear of the sticky flags
module sync_fifo_prog #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned FIFO_DEPTH    = 128,
  parameter int unsigned ADDR_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int unsigned FWFT          = 0,
  parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  wr_full_o,
  output logic                  rd_empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  err_clr_i
);

  localparam int unsigned LVL_W = ADDR_WIDTH + 1;

  // Parameter sanity checks at elaboration
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_prog: FIFO_DEPTH must be >= 2");
  end
  if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= FIFO_DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_prog: need AEMPTY_THRESH < AFULL_THRESH <= FIFO_DEPTH");
  end
  if (FWFT > 1) begin : g_bad_fwft
    $error("sync_fifo_prog: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc;
  logic [ADDR_WIDTH-1:0] rd_ptr_inc;
  logic [LVL_W-1:0]      level_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode the registered level only
  assign full           = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty          = (level_q == '0);
  assign wr_full_o      = full;
  assign rd_empty_o     = empty;
  assign almost_full_o  = (level_q >= LVL_W'(AFULL_THRESH));
  assign almost_empty_o = (level_q <= LVL_W'(AEMPTY_THRESH));
  assign level_o        = level_q;
  assign rd_data_o      = rd_data_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  assign wr_acc = wr_en_i & ~full;
  assign rd_acc = rd_en_i & ~empty;

  // Pointer increment with wrap at FIFO_DEPTH-1 (depth need not be 2^n)
  assign wr_ptr_inc = (wr_ptr_q == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
  assign rd_ptr_inc = (rd_ptr_q == ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);

  // Storage array, not reset
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers and level
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_inc;
      if (rd_acc) rd_ptr_q <= rd_ptr_inc;
      case ({wr_acc, rd_acc})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Read data register. In FWFT mode it tracks the head word after each edge:
  // the incoming word bypasses storage when it becomes the head.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (FWFT == 0) begin
      if (rd_acc) rd_data_q <= mem[rd_ptr_q];
    end else begin
      if (rd_acc) begin
        if (level_q == LVL_W'(1)) begin
          if (wr_acc) rd_data_q <= wr_data_i;
        end else begin
          rd_data_q <= mem[rd_ptr_inc];
        end
      end else if (empty && wr_acc) begin
        rd_data_q <= wr_data_i;
      end
    end
  end

  // Sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_en_i && full)    overflow_q <= 1'b1;
      else if (err_clr_i)     overflow_q <= 1'b0;
      if (rd_en_i && empty)   underflow_q <= 1'b1;
      else if (err_clr_i)     underflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench: standard-mode FIFO (depth 128) and FWFT FIFO (depth 5).
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Standard-mode instance
  logic        a_wr_en = 0, a_rd_en = 0, a_clr = 0;
  logic [15:0] a_wdata = '0, a_rdata;
  logic        a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [7:0]  a_level;

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(128), .FWFT(0)) u_std (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(a_wr_en), .wr_data_i(a_wdata),
    .rd_en_i(a_rd_en), .rd_data_o(a_rdata), .wr_full_o(a_full),
    .rd_empty_o(a_empty), .almost_full_o(a_afull), .almost_empty_o(a_aempty),
    .level_o(a_level), .overflow_o(a_ovf), .underflow_o(a_unf), .err_clr_i(a_clr)
  );

  // FWFT instance, non-power-of-two depth
  logic        b_wr_en = 0, b_rd_en = 0, b_clr = 0;
  logic [15:0] b_wdata = '0, b_rdata;
  logic        b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [3:0]  b_level;

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1),
                   .AFULL_THRESH(4), .AEMPTY_THRESH(1)) u_fwft (
    .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(b_wr_en), .wr_data_i(b_wdata),
    .rd_en_i(b_rd_en), .rd_data_o(b_rdata), .wr_full_o(b_full),
    .rd_empty_o(b_empty), .almost_full_o(b_afull), .almost_empty_o(b_aempty),
    .level_o(b_level), .overflow_o(b_ovf), .underflow_o(b_unf), .err_clr_i(b_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_level", 32'(a_level), 0);
    chk("rst_empty", 32'(a_empty), 1);
    chk("rst_aempty", 32'(a_aempty), 1);
    chk("rst_full", 32'(a_full), 0);
    chk("rst_afull", 32'(a_afull), 0);
    chk("rst_rdata", 32'(a_rdata), 0);
    chk("rst_flags", 32'({a_ovf, a_unf}), 0);
    step();
    rst_n = 1'b1;

    // Fill 1..128
    for (int i = 1; i <= 128; i++) begin
      a_wr_en = 1; a_wdata = 16'(i);
      step();
      chk("fill_level", 32'(a_level), 32'(i));
      chk("fill_afull", 32'(a_afull), 32'(i >= 124));
      chk("fill_full", 32'(a_full), 32'(i == 128));
      chk("fill_empty", 32'(a_empty), 0);
    end
    a_wr_en = 0;

    // Drain 128 in order
    for (int i = 1; i <= 128; i++) begin
      a_rd_en = 1;
      step();
      chk("drain_data", 32'(a_rdata), 32'(i));
      chk("drain_level", 32'(a_level), 32'(128 - i));
      chk("drain_aempty", 32'(a_aempty), 32'(128 - i <= 4));
    end
    a_rd_en = 0;
    chk("drain_empty", 32'(a_empty), 1);
    step();
    chk("hold_rdata", 32'(a_rdata), 32'h80);
    chk("no_err_yet", 32'({a_ovf, a_unf}), 0);

    // Refill, then simultaneous write/read while full
    for (int i = 1; i <= 128; i++) begin
      a_wr_en = 1; a_wdata = 16'(32'h100 + i);
      step();
    end
    a_wdata = 16'hDEAD; a_rd_en = 1;
    step();
    a_wr_en = 0; a_rd_en = 0;
    chk("fullrw_level", 32'(a_level), 127);
    chk("fullrw_ovf", 32'(a_ovf), 1);
    chk("fullrw_data", 32'(a_rdata), 32'h101);
    for (int i = 2; i <= 128; i++) begin
      a_rd_en = 1;
      step();
      chk("fullrw_drain", 32'(a_rdata), 32'h100 + 32'(i));
    end
    a_rd_en = 0;
    chk("fullrw_empty", 32'(a_empty), 1);

    // Simultaneous write/read while empty
    a_wr_en = 1; a_rd_en = 1; a_wdata = 16'h0055;
    step();
    a_wr_en = 0;
    chk("emptyrw_level", 32'(a_level), 1);
    chk("emptyrw_unf", 32'(a_unf), 1);
    chk("emptyrw_hold", 32'(a_rdata), 32'h180);
    step();
    a_rd_en = 0;
    chk("emptyrw_data", 32'(a_rdata), 32'h55);
    chk("emptyrw_empty", 32'(a_empty), 1);
    // Clear with a coincident empty read: underflow persists, overflow clears
    a_clr = 1; a_rd_en = 1;
    step();
    a_rd_en = 0;
    chk("clr_race_unf", 32'(a_unf), 1);
    chk("clr_race_ovf", 32'(a_ovf), 0);
    step();
    a_clr = 0;
    chk("clr_flags", 32'({a_ovf, a_unf}), 0);

    // Mid-operation asynchronous reset at level 60
    for (int i = 1; i <= 60; i++) begin
      a_wr_en = 1; a_wdata = 16'(32'h200 + i);
      step();
    end
    chk("pre_rst_level", 32'(a_level), 60);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(a_level), 0);
    chk("arst_empty", 32'(a_empty), 1);
    chk("arst_rdata", 32'(a_rdata), 0);
    step();
    chk("arst_nowrite", 32'(a_level), 0);
    rst_n = 1'b1;
    a_wdata = 16'h0777;
    step();
    a_wdata = 16'h0778;
    step();
    a_wr_en = 0; a_rd_en = 1;
    step();
    a_rd_en = 0;
    chk("post_rst_first", 32'(a_rdata), 32'h777);
    chk("post_rst_level", 32'(a_level), 1);

    // FWFT: word visible right after the write edge
    b_wr_en = 1; b_wdata = 16'hA5A5;
    step();
    b_wr_en = 0;
    chk("fwft_show", 32'(b_rdata), 32'hA5A5);
    chk("fwft_level1", 32'(b_level), 1);
    chk("fwft_nempty", 32'(b_empty), 0);
    b_rd_en = 1;
    step();
    b_rd_en = 0;
    chk("fwft_pop_empty", 32'(b_empty), 1);

    // 13 words through depth 5 across the wrap
    for (int j = 0; j < 3; j++) begin
      b_wr_en = 1; b_wdata = 16'(32'hB000 + j);
      step();
      chk("fwft_head_pre", 32'(b_rdata), 32'hB000);
    end
    for (int j = 3; j < 13; j++) begin
      b_wr_en = 1; b_rd_en = 1; b_wdata = 16'(32'hB000 + j);
      step();
      chk("fwft_head_rw", 32'(b_rdata), 32'hB000 + 32'(j - 2));
      chk("fwft_level_rw", 32'(b_level), 3);
    end
    b_wr_en = 0;
    for (int m = 1; m <= 2; m++) begin
      step();
      chk("fwft_head_pop", 32'(b_rdata), 32'hB000 + 32'(10 + m));
    end
    step();
    b_rd_en = 0;
    chk("fwft_wrap_empty", 32'(b_empty), 1);

    // FWFT level-1 read+write bypass
    b_wr_en = 1; b_wdata = 16'h00D1;
    step();
    b_rd_en = 1; b_wdata = 16'h00D2;
    step();
    b_wr_en = 0; b_rd_en = 0;
    chk("fwft_bypass", 32'(b_rdata), 32'hD2);
    chk("fwft_bypass_lvl", 32'(b_level), 1);

    // FWFT fill to full and overflow on simultaneous write/read
    for (int k = 2; k <= 5; k++) begin
      b_wr_en = 1; b_wdata = 16'(32'hC000 + k);
      step();
      chk("fwft_afull", 32'(b_afull), 32'(k >= 4));
      chk("fwft_full", 32'(b_full), 32'(k == 5));
    end
    b_rd_en = 1; b_wdata = 16'hBEEF;
    step();
    b_wr_en = 0; b_rd_en = 0;
    chk("fwft_ovf", 32'(b_ovf), 1);
    chk("fwft_ovf_lvl", 32'(b_level), 4);
    chk("fwft_ovf_head", 32'(b_rdata), 32'hC002);
    chk("fwft_unf", 32'(b_unf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
